// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-address/read-data arbiter in front of one shared read slave.
// Round-robin grant with one burst outstanding; flags bursts whose rlast disagrees with arlen.
module axi_rd_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  m_arvalid,
  input  logic [2*AXI_ADDR_WIDTH-1:0] m_araddr,
  input  logic [15:0]                 m_arlen,
  output logic [1:0]                  m_arready,
  output logic [1:0]                  m_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_rdata,
  output logic [1:0]                  m_rresp,
  output logic [1:0]                  m_rlast,
  input  logic [1:0]                  m_rready,
  output logic                        s_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  output logic [7:0]                  s_arlen,
  input  logic                        s_arready,
  input  logic                        s_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rlast,
  output logic                        s_rready,
  output logic [1:0]                  gnt,
  output logic                        busy,
  output logic                        proto_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  gnt_q, gnt_d;
  logic                        prio_q, prio_d;
  logic [7:0]                  beat_cnt_q, beat_cnt_d;
  logic [7:0]                  len_q, len_d;
  logic                        proto_err_q, proto_err_d;
  logic                        g;
  logic                        rd_hs;
  logic [AXI_ADDR_WIDTH-1:0]   sel_addr;
  logic [7:0]                  sel_len;

  // Ties go to the master named by prio; a lone requester always wins.
  function automatic logic [1:0] pick_winner(input logic [1:0] req, input logic p);
    logic [1:0] w;
    case (req)
      2'b01:   w = 2'b01;
      2'b10:   w = 2'b10;
      2'b11:   w = p ? 2'b10 : 2'b01;
      default: w = 2'b00;
    endcase
    return w;
  endfunction

  assign g        = gnt_q[1];
  assign sel_addr = g ? m_araddr[AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] : m_araddr[0 +: AXI_ADDR_WIDTH];
  assign sel_len  = g ? m_arlen[15:8] : m_arlen[7:0];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    prio_d      = prio_q;
    beat_cnt_d  = beat_cnt_q;
    len_d       = len_q;
    proto_err_d = proto_err_q;
    m_arready   = 2'b00;
    m_rvalid    = 2'b00;
    m_rlast     = 2'b00;
    m_rdata     = '0;
    m_rresp     = 2'b00;
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_arlen     = 8'd0;
    s_rready    = 1'b0;
    rd_hs       = 1'b0;

    case (state_q)
      IDLE: begin
        if (|m_arvalid) begin
          gnt_d   = pick_winner(m_arvalid, prio_q);
          state_d = ADDR;
        end
      end

      ADDR: begin
        s_arvalid = m_arvalid[g];
        s_araddr  = sel_addr;
        s_arlen   = sel_len;
        m_arready = g ? {s_arready, 1'b0} : {1'b0, s_arready};
        if (m_arvalid[g] && s_arready) begin
          len_d      = sel_len;
          beat_cnt_d = 8'd0;
          state_d    = DATA;
        end
      end

      DATA: begin
        s_rready = m_rready[g];
        m_rvalid = g ? {s_rvalid, 1'b0} : {1'b0, s_rvalid};
        m_rlast  = g ? {s_rlast, 1'b0} : {1'b0, s_rlast};
        m_rdata  = s_rdata;
        m_rresp  = s_rresp;
        rd_hs    = s_rvalid && m_rready[g];
        if (rd_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // A length mismatch is only reported; rlast alone closes the burst.
          if (s_rlast != (beat_cnt_q == len_q)) proto_err_d = 1'b1;
          if (s_rlast) begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            prio_d  = ~g;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      prio_q      <= 1'b0;
      beat_cnt_q  <= 8'd0;
      len_q       <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: scenario tasks check control outputs inline,
// a read-beat scoreboard checks routed data against beats the bench itself drove.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      m_arvalid;
  logic [2*AW-1:0] m_araddr;
  logic [15:0]     m_arlen;
  logic [1:0]      m_arready;
  logic [1:0]      m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic [1:0]      m_rlast;
  logic [1:0]      m_rready;
  logic            s_arvalid;
  logic [AW-1:0]   s_araddr;
  logic [7:0]      s_arlen;
  logic            s_arready;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            s_rready;
  logic [1:0]      gnt;
  logic            busy;
  logic            proto_err;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
    .gnt(gnt), .busy(busy), .proto_err(proto_err)
  );

  typedef struct {
    logic [1:0]    vld;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [1:0]    last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_cmp = 0;
  int    n_err = 0;

  // Drives one slave beat and records what the granted master must see.
  task automatic drive_beat(input int m, input bit last);
    beat_t b;
    logic [DW-1:0] d;
    logic [1:0] r;
    d = $urandom;
    r = 2'($urandom_range(0, 3));
    s_rvalid = 1'b1; s_rdata = d; s_rresp = r; s_rlast = last;
    b.vld  = (m == 1) ? 2'b10 : 2'b01;
    b.data = d;
    b.resp = r;
    b.last = last ? b.vld : 2'b00;
    exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if ((m_rvalid & m_rready) != 2'b00) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rbeat_unexpected: got rvalid=%b rlast=%b, required no beat", m_rvalid, m_rlast);
      end else begin
        mon_b = exp_q.pop_front();
        if ({m_rvalid, m_rdata, m_rresp, m_rlast} !== {mon_b.vld, mon_b.data, mon_b.resp, mon_b.last}) begin
          n_err++;
          $display("FAIL rbeat: got vld=%b data=%h resp=%b last=%b, required vld=%b data=%h resp=%b last=%b",
                   m_rvalid, m_rdata, m_rresp, m_rlast, mon_b.vld, mon_b.data, mon_b.resp, mon_b.last);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b required 00", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b required 0", proto_err); end
    n_cmp++; if ({m_arready, s_arvalid, s_rready, m_rvalid} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs: got arready=%b s_arvalid=%b s_rready=%b rvalid=%b required all 0",
                        m_arready, s_arvalid, s_rready, m_rvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0; m_arvalid = 2'b00; s_rvalid = 1'b0;
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h100; m_arlen[7:0] = 8'd7; m_rready = 2'b01;
    @(negedge clk);
    n_cmp++; if ({m_arready, s_arvalid} !== 3'b000) begin
      n_err++; $display("FAIL single_idle_no_hs: got arready=%b s_arvalid=%b required 00/0", m_arready, s_arvalid);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b required 01", gnt); end
    n_cmp++; if ({s_arvalid, s_araddr, s_arlen} !== {1'b1, 32'h100, 8'd7}) begin
      n_err++; $display("FAIL single_ar: got v=%b addr=%h len=%0d required 1/100/7", s_arvalid, s_araddr, s_arlen);
    end
    n_cmp++; if (m_arready !== 2'b01) begin n_err++; $display("FAIL single_arready: got %b required 01", m_arready); end
    @(posedge clk); #1;
    m_arvalid = 2'b00;
    for (int b = 0; b < 8; b++) begin
      drive_beat(0, b == 7);
      @(negedge clk);
      n_cmp++; if (s_rready !== 1'b1) begin n_err++; $display("FAIL single_rready beat %0d: got %b required 1", b, s_rready); end
      @(posedge clk); #1;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({gnt, busy, proto_err} !== 4'b0000) begin
      n_err++; $display("FAIL single_done: got gnt=%b busy=%b proto_err=%b required 00/0/0", gnt, busy, proto_err);
    end
  endtask

  task automatic test_both;
    logic [1:0] eg;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_araddr = {32'h300, 32'h200}; m_arlen = {8'd1, 8'd1}; m_arvalid = 2'b11; m_rready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      eg = (k == 1) ? 2'b10 : 2'b01;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL both_gnt burst %0d: got %b required %b", k, gnt, eg); end
      n_cmp++; if (s_araddr !== ((k == 1) ? 32'h300 : 32'h200)) begin
        n_err++; $display("FAIL both_addr burst %0d: got %h", k, s_araddr);
      end
      @(posedge clk); #1; drive_beat((k == 1) ? 1 : 0, 1'b0);
      @(posedge clk); #1; drive_beat((k == 1) ? 1 : 0, 1'b1);
      @(posedge clk); #1;
      s_rvalid = 1'b0; s_rlast = 1'b0;
      if (k == 2) m_arvalid = 2'b00;
      @(negedge clk);
      n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL both_release burst %0d: got %b required 00", k, gnt); end
    end
  endtask

  task automatic test_wait;
    @(posedge clk); #1;
    m_arvalid = 2'b01; m_araddr = {32'h500, 32'h400}; m_arlen = {8'd0, 8'd3}; m_rready = 2'b11;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL wait_gnt0: got %b required 01", gnt); end
    @(posedge clk); #1;
    m_arvalid = 2'b10;
    for (int b = 0; b < 4; b++) begin
      drive_beat(0, b == 3);
      @(negedge clk);
      n_cmp++; if (m_arready !== 2'b00) begin n_err++; $display("FAIL wait_arready beat %0d: got %b required 00", b, m_arready); end
      @(posedge clk); #1;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({gnt, m_arready} !== 4'b0000) begin
      n_err++; $display("FAIL wait_gap: got gnt=%b arready=%b required 00/00", gnt, m_arready);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL wait_gnt1: got %b required 10", gnt); end
    n_cmp++; if ({m_arready, s_araddr} !== {2'b10, 32'h500}) begin
      n_err++; $display("FAIL wait_ar1: got arready=%b addr=%h required 10/500", m_arready, s_araddr);
    end
    @(posedge clk); #1;
    m_arvalid = 2'b00; drive_beat(1, 1'b1);
    @(posedge clk); #1;
    s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wait_done: got busy=%b required 0", busy); end
  endtask

  task automatic test_early_last;
    @(posedge clk); #1;
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h800; m_arlen[7:0] = 8'd7; m_rready = 2'b01;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL early_gnt: got %b required 01", gnt); end
    @(posedge clk); #1;
    m_arvalid = 2'b00;
    for (int b = 0; b < 4; b++) begin
      drive_beat(0, b == 3);
      @(negedge clk);
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL early_pre beat %0d: got proto_err=%b required 0", b, proto_err); end
      @(posedge clk); #1;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({proto_err, busy, gnt} !== 4'b1000) begin
      n_err++; $display("FAIL early_end: got proto_err=%b busy=%b gnt=%b required 1/0/00", proto_err, busy, gnt);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL early_sticky: got %b required 1", proto_err); end
  endtask

  task automatic test_reset_mid;
    n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got proto_err=%b required 1", proto_err); end
    @(posedge clk); #1;
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h600; m_arlen[15:8] = 8'd7; m_rready = 2'b10;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rstmid_gnt: got %b required 10", gnt); end
    @(posedge clk); #1;
    m_arvalid = 2'b00;
    for (int b = 0; b < 3; b++) begin
      drive_beat(1, 1'b0);
      if (b == 2) rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, gnt, s_rready, m_rvalid} !== 6'b0) begin
      n_err++; $display("FAIL rstmid_state: got busy=%b gnt=%b s_rready=%b rvalid=%b required all 0", busy, gnt, s_rready, m_rvalid);
    end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rstmid_proto_err: got %b required 0", proto_err); end
    s_rvalid = 1'b0;
  endtask

  task automatic test_single_beat;
    @(posedge clk); #1;
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h700; m_arlen[7:0] = 8'd0; m_rready = 2'b01;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({gnt, s_arlen} !== {2'b01, 8'd0}) begin
      n_err++; $display("FAIL sbeat_ar: got gnt=%b len=%0d required 01/0", gnt, s_arlen);
    end
    @(posedge clk); #1;
    m_arvalid = 2'b00; drive_beat(0, 1'b1);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sbeat_busy: got %b required 1", busy); end
    @(posedge clk); #1;
    s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, gnt, proto_err} !== 4'b0000) begin
      n_err++; $display("FAIL sbeat_done: got busy=%b gnt=%b proto_err=%b required 0/00/0", busy, gnt, proto_err);
    end
  endtask

  initial begin
    rst = 1'b1; m_arvalid = 2'b00; m_araddr = '0; m_arlen = '0; m_rready = 2'b00;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_wait();
    test_early_last();
    test_reset_mid();
    test_single_beat();
    repeat (2) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL beats_left: got %0d undelivered required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, SHALL set the read address width.
REQ-003 Parameter AXI_DATA_WIDTH, default 32, SHALL set the read data width.
REQ-004 The ports SHALL be as follows (clock and reset first):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_arvalid  in  2  per-master address valid; bit i belongs to master i
- m_araddr  in  2xAXI_ADDR_WIDTH  per-master address
- m_arlen  in  2x8  per-master burst length minus 1
- m_arready  out  2  per-master address ready
- m_rvalid  out  2  per-master read data valid
- m_rdata  out  AXI_DATA_WIDTH  read data, shared by both masters
- m_rresp  out  2  read response, shared by both masters
- m_rlast  out  2  per-master last beat
- m_rready  in  2  per-master read ready
- s_arvalid / s_araddr / s_arlen  out  1 / AXI_ADDR_WIDTH / 8  address request to the shared instruction-memory read slave
- s_arready  in  1  slave address ready
- s_rvalid / s_rdata / s_rresp / s_rlast  in  1 / AXI_DATA_WIDTH / 2 / 1  slave read data channel
- s_rready  out  1  read ready to slave
- gnt  out  2  one-hot current grant; 00 when idle
- busy  out  1  high in any state other than IDLE
- proto_err  out  1  sticky burst-length mismatch flag

Function
REQ-005 The FSM SHALL have three states: IDLE, ADDR and DATA, and SHALL allow exactly one outstanding burst at a time.
REQ-006 In IDLE with any m_arvalid high, the FSM SHALL register the winner into gnt and move to ADDR on the next edge. With no request, it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin using a 1-bit priority pointer prio:
- if only one master requests, that master wins;
- if both request, master prio wins.
REQ-008 prio SHALL be set to the non-granted master's index on each burst completion (REQ-012).
REQ-009 In IDLE, m_arready SHALL be 00 and s_arvalid SHALL be 0; a request never completes a handshake in IDLE.
REQ-010 In ADDR:
- s_arvalid, s_araddr and s_arlen SHALL combinationally mirror the granted master's signals;
- m_arready[g] SHALL equal s_arready, and the other bit SHALL be 0;
- on s_arvalid && s_arready, the block SHALL latch arlen into len_q, clear beat_cnt to 0, and go to DATA.
REQ-011 In DATA:
- m_rvalid[g] SHALL equal s_rvalid, and m_rlast[g] SHALL equal s_rlast;
- m_rdata and m_rresp SHALL pass s_rdata and s_rresp through;
- s_rready SHALL equal m_rready[g];
- the non-granted master's rvalid and rlast SHALL be 0.
REQ-012 The handshake s_rvalid && s_rready in DATA SHALL increment beat_cnt (8-bit). On a handshake with s_rlast=1, the FSM SHALL go to IDLE, update prio, and clear gnt on the same edge.
REQ-013 Outside DATA, s_rready and m_rvalid SHALL be 0; slave data arriving in IDLE or ADDR SHALL be ignored.
REQ-014 proto_err SHALL set on a DATA beat handshake when either:
- s_rlast=1 and beat_cnt!=len_q, or
- s_rlast=0 and beat_cnt==len_q.
proto_err SHALL clear only on rst. A mismatch SHALL NOT alter FSM sequencing: only s_rlast ends the burst.
REQ-015 Latency: arvalid sampled in IDLE at edge N SHALL give s_arvalid=1 in cycle N+1, so the minimum address-path overhead is one cycle. After the rlast handshake at edge M, a new grant SHALL register no earlier than edge M+1.
REQ-016 A master deasserting arvalid while in IDLE SHALL create no grant. A granted master SHALL keep arvalid asserted until its handshake, per AXI; the arbiter does not check this.
REQ-017 A request arriving during ADDR or DATA of the other master SHALL wait with m_arready=0 and SHALL be served next if still valid.
REQ-018 len_q=0 (single beat) SHALL be legal: one beat with rlast returns the FSM to IDLE.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL set:
- FSM to IDLE;
- gnt, prio, beat_cnt, len_q, busy and proto_err to 0;
- all m_* and s_* outputs driven by the block to 0.
REQ-020 Reset mid-burst SHALL abandon the burst without completing the handshake. Resetting the downstream slave together with this block is the system's responsibility.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Only master 0 requests, addr 0x100, arlen 7 -> gnt=01, s_araddr=0x100, s_arlen=7, eight beats routed to master 0, rlast on beat 7, gnt=00 the cycle after, proto_err=0.
- Both masters request in IDLE after reset -> master 0 served first, then master 1, then master 0 again when both keep requesting.
- Master 1 requests while master 0 is in DATA -> m_arready[1] stays 0 until master 0's rlast, then gnt=10 on the next edge.
- Slave asserts rlast on beat 3 while arlen=7 -> proto_err=1 and sticky, FSM returns to IDLE.
- arlen=0 -> a single beat with rlast completes the burst, busy drops the next cycle.
- rst asserted in DATA during beat 2 -> next cycle: IDLE, gnt=00, s_rready=0, proto_err=0.
